qea_host_loader: RTL

QEA_HOST_LOADER -- requirements
Module: qea_host_loader

---
 rtl/qea_host_pkg.sv | 17 +
 rtl/qea_word_serializer.sv | 49 ++++
 rtl/qea_host_loader.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/qea_host_pkg.sv
// Shared definitions for the QEA host loader: controller states and the
// number of stream beats packed into one state RAM address.
package qea_host_pkg;
  localparam int BEATS_PER_ADDR = 4;

  typedef enum logic [3:0] {
    IDLE,
    LD_CTX,
    LD_STATE,
    START,
    RUN,
    RD_REQ,
    RD_WAIT,
    DRAIN,
    DONE
  } qea_state_e;
endpackage

// File: rtl/qea_word_serializer.sv
// Splits one wide state word into BEATS narrow stream beats, most significant
// slice first, with valid/ready flow control on both sides.
module qea_word_serializer #(
  parameter int BEATS = 4,
  parameter int W     = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [BEATS*W-1:0]   i_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [W-1:0]         o_data,
  output logic                 o_last
);
  localparam int CW = $clog2(BEATS + 1);

  logic [BEATS*W-1:0] buf_q, buf_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  assign o_valid = (cnt_q != '0);
  assign o_ready = (cnt_q == '0);
  assign o_data  = buf_q[BEATS*W-1 -: W];
  assign o_last  = o_valid && i_ready && (cnt_q == CW'(1));

  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    if (i_valid && o_ready) begin
      buf_d = i_data;
      cnt_d = CW'(BEATS);
    end else if (o_valid && i_ready) begin
      // Shift the next slice into the output window; data is frozen while stalled.
      buf_d = {buf_q[BEATS*W-W-1:0], {W{1'b0}}};
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/qea_host_loader.sv
// Host-side loader for the QEA: streams context and state words into the RAMs,
// launches the engine, times it, then streams the resulting state back out.
module qea_host_loader
  import qea_host_pkg::*;
#(
  parameter int PE_NUM                  = BEATS_PER_ADDR,
  parameter int STATE_DATA_WIDTH        = 64,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_CONTEXT_DATA_WIDTH = 64,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int MAX_QBIT_WIDTH          = 6
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_go,
  input  logic [MAX_QBIT_WIDTH-1:0]          i_qbit_num,
  input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] i_ins_num,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [STATE_DATA_WIDTH-1:0]        s_data,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [STATE_DATA_WIDTH-1:0]        m_data,
  output logic                               o_busy,
  output logic                               o_done,
  output logic [31:0]                        o_cycles,
  output logic                               o_start,
  output logic [MAX_QBIT_WIDTH-1:0]          o_qbit_num,
  output logic                               o_ctx_en,
  output logic                               o_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0] o_ctx_addr,
  output logic [GATE_CONTEXT_DATA_WIDTH-1:0] o_ctx_data,
  output logic [PE_NUM-1:0]                  o_state_ena,
  output logic [PE_NUM-1:0]                  o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]        o_state_addra,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0] o_state_dina,
  input  logic                               i_complete,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0] i_state_dout
);
  localparam int SDW  = STATE_DATA_WIDTH;
  localparam int BW   = PE_NUM * SDW;
  localparam int SAW  = STATE_ADDR_WIDTH;
  localparam int CAW  = GATE_CONTEXT_ADDR_WIDTH;
  localparam int QW   = MAX_QBIT_WIDTH;
  localparam int BTW  = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;

  qea_state_e           state_q, state_d;
  logic [QW-1:0]        qbit_q, qbit_d;
  logic [CAW-1:0]       ins_q, ins_d;
  logic [CAW-1:0]       ctx_cnt_q, ctx_cnt_d;
  logic                 ctx_we_q, ctx_we_d;
  logic [CAW-1:0]       ctx_addr_q, ctx_addr_d;
  logic [GATE_CONTEXT_DATA_WIDTH-1:0] ctx_data_q, ctx_data_d;
  logic [BTW-1:0]       beat_q, beat_d;
  logic [BW-1:0]        pack_q, pack_d;
  logic [SAW-1:0]       grp_q, grp_d;
  logic                 st_we_q, st_we_d;
  logic [SAW-1:0]       st_addr_q, st_addr_d;
  logic [BW-1:0]        st_din_q, st_din_d;
  logic [SAW-1:0]       rd_addr_q, rd_addr_d;
  logic [31:0]          cyc_q, cyc_d;

  logic                 s_beat;
  logic [SAW-1:0]       last_addr;
  logic                 ser_load, ser_in_ready, ser_last;

  // Address count is 2^(qbit-2); fewer than two qubits still occupy one address.
  assign last_addr = (qbit_q < QW'(2)) ? '0
                   : SAW'((32'd1 << (qbit_q - QW'(2))) - 32'd1);

  assign s_ready       = (state_q == LD_CTX) || (state_q == LD_STATE);
  assign s_beat        = s_valid && s_ready;
  assign o_busy        = (state_q != IDLE);
  assign o_start       = (state_q == START);
  assign o_done        = (state_q == DONE);
  assign o_cycles      = cyc_q;
  assign o_qbit_num    = qbit_q;
  assign o_ctx_en      = ctx_we_q;
  assign o_ctx_wea     = ctx_we_q;
  assign o_ctx_addr    = ctx_addr_q;
  assign o_ctx_data    = ctx_data_q;
  assign o_state_ena   = (st_we_q || (state_q == RD_REQ)) ? '1 : '0;
  assign o_state_wea   = st_we_q ? '1 : '0;
  assign o_state_addra = (state_q == RD_REQ) ? rd_addr_q : st_addr_q;
  assign o_state_dina  = st_din_q;

  always_comb begin
    state_d    = state_q;
    qbit_d     = qbit_q;
    ins_d      = ins_q;
    ctx_cnt_d  = ctx_cnt_q;
    ctx_we_d   = 1'b0;
    ctx_addr_d = ctx_addr_q;
    ctx_data_d = ctx_data_q;
    beat_d     = beat_q;
    pack_d     = pack_q;
    grp_d      = grp_q;
    st_we_d    = 1'b0;
    st_addr_d  = st_addr_q;
    st_din_d   = st_din_q;
    rd_addr_d  = rd_addr_q;
    cyc_d      = cyc_q;
    ser_load   = 1'b0;
    case (state_q)
      IDLE: if (i_go) begin
        qbit_d    = i_qbit_num;
        ins_d     = i_ins_num;
        ctx_cnt_d = '0;
        beat_d    = '0;
        grp_d     = '0;
        rd_addr_d = '0;
        state_d   = (i_ins_num == '0) ? LD_STATE : LD_CTX;
      end
      LD_CTX: if (s_beat) begin
        ctx_we_d   = 1'b1;
        ctx_addr_d = ctx_cnt_q;
        ctx_data_d = s_data;
        ctx_cnt_d  = ctx_cnt_q + CAW'(1);
        if (ctx_cnt_d == ins_q) state_d = LD_STATE;
      end
      LD_STATE: if (s_beat) begin
        // First beat of a group ends up in the top slice after PE_NUM shifts.
        pack_d = {pack_q[BW-SDW-1:0], s_data};
        beat_d = beat_q + BTW'(1);
        if (beat_q == BTW'(PE_NUM - 1)) begin
          beat_d    = '0;
          st_we_d   = 1'b1;
          st_addr_d = grp_q;
          st_din_d  = pack_d;
          grp_d     = grp_q + SAW'(1);
          if (grp_q == last_addr) state_d = START;
        end
      end
      START: begin
        cyc_d   = 32'd1;
        state_d = RUN;
      end
      RUN: begin
        cyc_d = cyc_q + 32'd1;
        if (i_complete) state_d = RD_REQ;
      end
      RD_REQ: state_d = RD_WAIT;
      RD_WAIT: if (ser_in_ready) begin
        ser_load = 1'b1;
        state_d  = DRAIN;
      end
      DRAIN: if (ser_last) begin
        rd_addr_d = rd_addr_q + SAW'(1);
        state_d   = (rd_addr_q == last_addr) ? DONE : RD_REQ;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      qbit_q     <= '0;
      ins_q      <= '0;
      ctx_cnt_q  <= '0;
      ctx_we_q   <= 1'b0;
      ctx_addr_q <= '0;
      ctx_data_q <= '0;
      beat_q     <= '0;
      pack_q     <= '0;
      grp_q      <= '0;
      st_we_q    <= 1'b0;
      st_addr_q  <= '0;
      st_din_q   <= '0;
      rd_addr_q  <= '0;
      cyc_q      <= '0;
    end else begin
      state_q    <= state_d;
      qbit_q     <= qbit_d;
      ins_q      <= ins_d;
      ctx_cnt_q  <= ctx_cnt_d;
      ctx_we_q   <= ctx_we_d;
      ctx_addr_q <= ctx_addr_d;
      ctx_data_q <= ctx_data_d;
      beat_q     <= beat_d;
      pack_q     <= pack_d;
      grp_q      <= grp_d;
      st_we_q    <= st_we_d;
      st_addr_q  <= st_addr_d;
      st_din_q   <= st_din_d;
      rd_addr_q  <= rd_addr_d;
      cyc_q      <= cyc_d;
    end
  end

  qea_word_serializer #(.BEATS(PE_NUM), .W(SDW)) u_ser (
    .clk     (clk),
    .rst     (rst),
    .i_valid (ser_load),
    .o_ready (ser_in_ready),
    .i_data  (i_state_dout),
    .o_valid (m_valid),
    .i_ready (m_ready),
    .o_data  (m_data),
    .o_last  (ser_last)
  );
endmodule
